vga_test_source: RTL and testbench
==================================

VGA_TEST_SOURCE -- requirements
Module: vga_test_source

Interface
REQ-001 SHALL have parameter WIDTH, default 800: active pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 480: active lines per frame.
REQ-003 SHALL have parameters H_FP=40, H_SYNC=48, H_BP=40, V_FP=13, V_SYNC=3, V_BP=29: porch and sync lengths in pixels or lines.
REQ-004 SHALL have port VGA_CLK, input, 1 bit: 25 MHz pixel clock, the only clock.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port mode, input, 2 bits: pattern select.
REQ-007 SHALL have port solid_rgb, input, 24 bits: {R,G,B} colour for mode 0.
REQ-008 SHALL have ports oVGA_R, oVGA_G, oVGA_B, output, 8 bits each: pixel colour.
REQ-009 SHALL have ports oVGA_HS, oVGA_VS, oVGA_SYNC_N, oVGA_BLANK_N, output, 1 bit each: sync and blank, same meaning as the Filter inputs.
REQ-010 SHALL have port frame_start, output, 1 bit: one-cycle pulse aligned with pixel (0,0).
REQ-011 SHALL have port frame_count, output, 16 bits: completed-frame counter.

Function
REQ-012 SHALL keep h_cnt in 0..H_TOTAL-1, with H_TOTAL=WIDTH+H_FP+H_SYNC+H_BP (928 by default), incrementing every cycle and wrapping to 0.
REQ-013 SHALL keep v_cnt in 0..V_TOTAL-1, with V_TOTAL=525 by default; v_cnt increments only on the cycle h_cnt wraps, and wraps to 0 after V_TOTAL-1.
REQ-014 SHALL drive oVGA_HS low iff WIDTH+H_FP <= h_cnt < WIDTH+H_FP+H_SYNC, and oVGA_VS low iff HEIGHT+V_FP <= v_cnt < HEIGHT+V_FP+V_SYNC.
REQ-015 SHALL drive oVGA_BLANK_N high iff h_cnt<WIDTH and v_cnt<HEIGHT; SHALL hold oVGA_SYNC_N at 0.
REQ-016 SHALL force RGB to 0 whenever oVGA_BLANK_N is low.
REQ-017 SHALL register all outputs in one stage, giving exactly 1 cycle of latency from counter state to pins, with sync, blank and RGB mutually aligned.
REQ-018 SHALL sample mode and solid_rgb only at h_cnt=0, v_cnt=0, so a change mid-frame takes effect at the next frame.
REQ-019 Mode 0 SHALL output solid_rgb.
REQ-020 Mode 1 SHALL output a grey ramp, R=G=B=(h_cnt+offset)[7:0].
REQ-021 Mode 2 SHALL output a checkerboard: white if h_cnt[4]^v_cnt[4], else black.
REQ-022 Mode 3 SHALL output 8 colour bars, each WIDTH/8 px wide; bar index k sets R=255*k[2], G=255*k[1], B=255*k[0].
REQ-023 SHALL pulse frame_start on the output cycle carrying pixel (0,0).
REQ-024 SHALL increment frame_count on the last cycle of each frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1), wrapping from 0xFFFF to 0.

Reset
REQ-025 While reset_n is low, the block SHALL hold h_cnt=0, v_cnt=0, frame_count=0, RGB=0, HS=1, VS=1, BLANK_N=0, SYNC_N=0, frame_start=0, and latched mode=0.
REQ-026 After reset_n deasserts mid-frame, the first output cycle SHALL be pixel (0,0) with frame_start=1.

Configuration
REQ-027 With VGA_SRC_SCROLL_EN defined, offset SHALL equal frame_count[7:0], scrolling the mode-1 ramp 1 px per frame.
REQ-028 Without VGA_SRC_SCROLL_EN, offset SHALL be 0 and frame_count SHALL still count.

Structure
REQ-029 Package vga_pkg SHALL hold the default timing constants, the H_TOTAL/V_TOTAL derivation and the pattern-mode enum (SOLID, RAMP, CHECKER, BARS).
REQ-030 Sub-module vga_timing_gen SHALL own the h/v counters, sync/blank decode and frame events; vga_test_source SHALL add the pattern logic and the output register.

Verification
REQ-031 Reset released, 2 frames run -> HS period 928 cycles, low 48 cycles; VS period 487200 cycles, low 3 lines; 384000 BLANK_N-high cycles per frame.
REQ-032 mode=0, solid_rgb=0x12_34_56 -> every active pixel is R=0x12, G=0x34, B=0x56; every blank pixel is 0.
REQ-033 mode=1, scroll disabled -> pixel x=300 has R=G=B=44; with VGA_SRC_SCROLL_EN, frame 3 pixel x=300 has value 47.
REQ-034 mode switches 0->3 at line 100 -> current frame stays solid; next frame pixel x=150 is R=0, G=0, B=255.
REQ-035 reset_n pulsed low at h=500, v=200 -> outputs take reset values asynchronously; first cycle after release is (0,0) with frame_start=1.
REQ-036 frame_count forced to 0xFFFF -> reads 0x0000 after the next frame end.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default VGA timing constants, totals derivation and pattern types
package vga_pkg;

    // 640x480-class panel timing on a 25 MHz pixel clock, widened to 800 active pixels
    localparam int DEF_WIDTH  = 800;
    localparam int DEF_HEIGHT = 480;
    localparam int DEF_H_FP   = 40;
    localparam int DEF_H_SYNC = 48;
    localparam int DEF_H_BP   = 40;
    localparam int DEF_V_FP   = 13;
    localparam int DEF_V_SYNC = 3;
    localparam int DEF_V_BP   = 29;

    // Counter width; wide enough for any practical line or frame length
    localparam int CNT_W = 12;

    // Total period of one axis: active region plus front porch, sync and back porch
    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_WIDTH, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = axis_total(DEF_HEIGHT, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    typedef enum logic [1:0] {
        SOLID   = 2'd0,
        RAMP    = 2'd1,
        CHECKER = 2'd2,
        BARS    = 2'd3
    } pattern_mode_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t RGB_WHITE = 24'hFF_FF_FF;
    localparam rgb_t RGB_BLACK = 24'h00_00_00;

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - h/v raster counters with sync, blank and frame-event decode
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP
) (
    input  logic       VGA_CLK,
    input  logic       reset_n,
    output logic [7:0] h_lsb,
    output logic       v_tile,
    output logic       hs_n,
    output logic       vs_n,
    output logic       active,
    output logic       frame_first,
    output logic       line_last,
    output logic       frame_last
);

    localparam int H_TOTAL = axis_total(WIDTH, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(HEIGHT, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] H_SS    = CNT_W'(WIDTH + H_FP);
    localparam logic [CNT_W-1:0] H_SE    = CNT_W'(WIDTH + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(HEIGHT);
    localparam logic [CNT_W-1:0] V_SS    = CNT_W'(HEIGHT + V_FP);
    localparam logic [CNT_W-1:0] V_SE    = CNT_W'(HEIGHT + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    assign line_last   = (h_cnt == H_LAST);
    assign frame_last  = line_last && (v_cnt == V_LAST);
    assign frame_first = (h_cnt == '0) && (v_cnt == '0);

    // Sync pulses are active low inside their window; blank covers everything outside the active area
    assign hs_n   = !((h_cnt >= H_SS) && (h_cnt < H_SE));
    assign vs_n   = !((v_cnt >= V_SS) && (v_cnt < V_SE));
    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);

    // Only the bits the pattern generators need leave this block
    assign h_lsb  = h_cnt[7:0];
    assign v_tile = v_cnt[4];

    // Raster scan: h advances every pixel, v advances on the h wrap, both wrap at end of frame
    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_last) begin
            h_cnt <= '0;
            v_cnt <= frame_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_test_source.sv
// rtl/vga_test_source.sv - VGA test pattern source; VGA_SRC_SCROLL_EN scrolls the ramp by frame count
module vga_test_source
    import vga_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP
) (
    input  logic        VGA_CLK,
    input  logic        reset_n,
    input  logic [1:0]  mode,
    input  logic [23:0] solid_rgb,
    output logic [7:0]  oVGA_R,
    output logic [7:0]  oVGA_G,
    output logic [7:0]  oVGA_B,
    output logic        oVGA_HS,
    output logic        oVGA_VS,
    output logic        oVGA_SYNC_N,
    output logic        oVGA_BLANK_N,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    // Colour bar width; clamped so tiny test rasters still get a legal counter
    localparam int BAR_W = (WIDTH / 8 > 0) ? WIDTH / 8 : 1;
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

    logic [7:0]       h_lsb;
    logic             v_tile;
    logic             hs_n;
    logic             vs_n;
    logic             active;
    logic             frame_first;
    logic             line_last;
    logic             frame_last;

    pattern_mode_e    mode_q;
    rgb_t             rgb_q;
    pattern_mode_e    eff_mode;
    rgb_t             eff_rgb;
    rgb_t             pix_d;
    logic [7:0]       offset;
    logic [7:0]       ramp;
    logic [CNT_W-1:0] bar_px;
    logic [2:0]       bar_k;
    logic [15:0]      frame_cnt_q;

    vga_timing_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_timing (
        .VGA_CLK     (VGA_CLK),
        .reset_n     (reset_n),
        .h_lsb       (h_lsb),
        .v_tile      (v_tile),
        .hs_n        (hs_n),
        .vs_n        (vs_n),
        .active      (active),
        .frame_first (frame_first),
        .line_last   (line_last),
        .frame_last  (frame_last)
    );

`ifdef VGA_SRC_SCROLL_EN
    assign offset = frame_cnt_q[7:0];
`else
    assign offset = 8'd0;
`endif

    assign ramp = h_lsb + offset;

    // Pixel (0,0) already uses the freshly sampled settings so a whole frame is uniform
    assign eff_mode = frame_first ? pattern_mode_e'(mode) : mode_q;
    assign eff_rgb  = frame_first ? rgb_t'(solid_rgb) : rgb_q;

    assign oVGA_SYNC_N = 1'b0;
    assign frame_count = frame_cnt_q;

    // Pattern settings are captured once per frame at the first pixel
    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= SOLID;
            rgb_q  <= RGB_BLACK;
        end else if (frame_first) begin
            mode_q <= pattern_mode_e'(mode);
            rgb_q  <= rgb_t'(solid_rgb);
        end
    end

    // Bar index tracks h position without a divider; saturates past the last bar
    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            bar_px <= '0;
            bar_k  <= '0;
        end else if (line_last) begin
            bar_px <= '0;
            bar_k  <= '0;
        end else if (bar_px == BAR_LAST) begin
            bar_px <= '0;
            bar_k  <= (bar_k == 3'd7) ? 3'd7 : bar_k + 3'd1;
        end else begin
            bar_px <= bar_px + 1'b1;
        end
    end

    // Completed-frame counter, bumped on the final pixel of each frame
    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
        end else if (frame_last) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    // Pattern select; anything outside the active area is black
    always_comb begin
        pix_d = RGB_BLACK;
        if (active) begin
            case (eff_mode)
                SOLID:   pix_d = eff_rgb;
                RAMP:    pix_d = {ramp, ramp, ramp};
                CHECKER: pix_d = (h_lsb[4] ^ v_tile) ? RGB_WHITE : RGB_BLACK;
                BARS:    pix_d = {{8{bar_k[2]}}, {8{bar_k[1]}}, {8{bar_k[0]}}};
                default: pix_d = RGB_BLACK;
            endcase
        end
    end

    // Single output stage keeps colour, sync, blank and frame_start mutually aligned
    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            oVGA_R       <= 8'd0;
            oVGA_G       <= 8'd0;
            oVGA_B       <= 8'd0;
            oVGA_HS      <= 1'b1;
            oVGA_VS      <= 1'b1;
            oVGA_BLANK_N <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            oVGA_R       <= pix_d.r;
            oVGA_G       <= pix_d.g;
            oVGA_B       <= pix_d.b;
            oVGA_HS      <= hs_n;
            oVGA_VS      <= vs_n;
            oVGA_BLANK_N <= active;
            frame_start  <= frame_first;
        end
    end

endmodule

// File: tb/tb_vga_test_source.sv
// tb/tb_vga_test_source.sv - randomized self-checking bench against a raster reference model
module tb_vga_test_source;

    localparam int W   = 64;
    localparam int H   = 40;
    localparam int HFP = 4;
    localparam int HSY = 6;
    localparam int HBP = 6;
    localparam int VFP = 2;
    localparam int VSY = 3;
    localparam int VBP = 3;
    localparam int HT  = W + HFP + HSY + HBP;
    localparam int VT  = H + VFP + VSY + VBP;

    localparam logic [44:0] RST_VEC = {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};

    logic        VGA_CLK = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  mode;
    logic [23:0] solid_rgb;
    logic [7:0]  oVGA_R;
    logic [7:0]  oVGA_G;
    logic [7:0]  oVGA_B;
    logic        oVGA_HS;
    logic        oVGA_VS;
    logic        oVGA_SYNC_N;
    logic        oVGA_BLANK_N;
    logic        frame_start;
    logic [15:0] frame_count;

    int checks   = 0;
    int failures = 0;

    wire [44:0] obs = {oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS, oVGA_SYNC_N, oVGA_BLANK_N,
                       frame_start, frame_count};

    always #5 VGA_CLK = ~VGA_CLK;

    vga_test_source #(
        .WIDTH  (W),
        .HEIGHT (H),
        .H_FP   (HFP),
        .H_SYNC (HSY),
        .H_BP   (HBP),
        .V_FP   (VFP),
        .V_SYNC (VSY),
        .V_BP   (VBP)
    ) dut (
        .VGA_CLK      (VGA_CLK),
        .reset_n      (reset_n),
        .mode         (mode),
        .solid_rgb    (solid_rgb),
        .oVGA_R       (oVGA_R),
        .oVGA_G       (oVGA_G),
        .oVGA_B       (oVGA_B),
        .oVGA_HS      (oVGA_HS),
        .oVGA_VS      (oVGA_VS),
        .oVGA_SYNC_N  (oVGA_SYNC_N),
        .oVGA_BLANK_N (oVGA_BLANK_N),
        .frame_start  (frame_start),
        .frame_count  (frame_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected pin state for raster position (x,y) given the frame's mode/colour
    function automatic logic [44:0] ref_vec(input int x, input int y, input logic [1:0] m,
                                            input logic [23:0] rgb, input int off, input int fc);
        logic [7:0]  r, g, b;
        logic [15:0] fc16;
        logic        act, hs, vs, fs;
        int          v, k;
        r = 8'h00; g = 8'h00; b = 8'h00;
        act  = (x < W) && (y < H);
        hs   = !((x >= W + HFP) && (x < W + HFP + HSY));
        vs   = !((y >= H + VFP) && (y < H + VFP + VSY));
        fs   = (x == 0) && (y == 0);
        fc16 = fc[15:0];
        if (act) begin
            case (m)
                2'd0: {r, g, b} = rgb;
                2'd1: begin
                    v = (x + off) % 256;
                    r = v[7:0]; g = v[7:0]; b = v[7:0];
                end
                2'd2: if (((x / 16) % 2) != ((y / 16) % 2)) begin
                    r = 8'hFF; g = 8'hFF; b = 8'hFF;
                end
                default: begin
                    k = x / (W / 8);
                    r = ((k / 4) % 2 == 1) ? 8'hFF : 8'h00;
                    g = ((k / 2) % 2 == 1) ? 8'hFF : 8'h00;
                    b = (k % 2 == 1)       ? 8'hFF : 8'h00;
                end
            endcase
        end
        return {r, g, b, hs, vs, 1'b0, act, fs, fc16};
    endfunction

    int          k_pix;
    int          exp_fc;
    int          gframe;
    int          x, y, off;
    int          hs_lo, vs_lo, bl_hi;
    logic        last;
    logic [1:0]  f_mode;
    logic [23:0] f_rgb;

    initial begin
        mode      = 2'd0;
        solid_rgb = 24'h12_34_56;
        reset_n   = 1'b0;
        hs_lo = 0; vs_lo = 0; bl_hi = 0;
        f_mode = 2'd0; f_rgb = 24'h0;
        repeat (3) begin
            @(negedge VGA_CLK);
            check("reset_state", obs, RST_VEC);
        end
        reset_n = 1'b1;
        k_pix = 0; exp_fc = 0; gframe = 0;

        while (gframe < 10) begin
            @(negedge VGA_CLK);
            x = k_pix % HT;
            y = (k_pix / HT) % VT;
            if (x == 0 && y == 0) begin
                f_mode = mode;
                f_rgb  = solid_rgb;
            end
`ifdef VGA_SRC_SCROLL_EN
            off = exp_fc % 256;
`else
            off = 0;
`endif
            last = (x == HT - 1) && (y == VT - 1);
            if (last) exp_fc = (exp_fc + 1) % 65536;
            check($sformatf("pix g%0d x%0d y%0d m%0d", gframe, x, y, f_mode), obs,
                  ref_vec(x, y, f_mode, f_rgb, off, exp_fc));
            if (gframe == 1) begin
                if (!oVGA_HS) hs_lo++;
                if (!oVGA_VS) vs_lo++;
                if (oVGA_BLANK_N) bl_hi++;
            end
            k_pix++;
            if (last) begin
                if (gframe == 1) begin
                    check("hs_low_cycles", hs_lo, HSY * VT);
                    check("vs_low_cycles", vs_lo, VSY * HT);
                    check("blank_hi_cycles", bl_hi, W * H);
                end
                gframe++;
            end

            // Scripted mid-frame changes, each taking effect on the following frame
            if (gframe == 0 && y == 10 && x == 0) mode = 2'd3;
            if (gframe == 1 && y == 5 && x == 0) mode = 2'd1;
            if (gframe == 2 && y == 5 && x == 0) mode = 2'd2;
            if (gframe == 3 && y == 5 && x == 0) begin
                mode      = 2'd1;
                solid_rgb = $urandom;
            end
            if (gframe >= 4 && gframe < 9 && $urandom_range(0, 499) == 0) begin
                mode      = 2'($urandom_range(0, 3));
                solid_rgb = $urandom;
            end

            // Asynchronous reset pulse in the middle of a frame
            if (gframe == 5 && y == 20 && x == 30) begin
                reset_n = 1'b0;
                #1;
                check("reset_async", obs, RST_VEC);
                repeat (3) begin
                    @(negedge VGA_CLK);
                    check("reset_hold", obs, RST_VEC);
                end
                reset_n = 1'b1;
                k_pix = 0; exp_fc = 0;
                gframe++;
            end

            // Preload the frame counter just below wrap
            if (gframe == 7 && y == 3 && x == 5) begin
                force dut.frame_cnt_q = 16'hFFFF;
                #1;
                release dut.frame_cnt_q;
                exp_fc = 16'hFFFF;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
